result_frame_sink: RTL
======================

Name: result_frame_sink

Overview:
- Receiving end of the pixel result interface (column, row, 3-bit R/G/B, write enable) that the thresholding pipeline drives.
- Stores incoming result pixels in an on-chip frame buffer.
- Continuously raster-scans the buffer out as a timed pixel stream with sync pulses for the display side.
- Also counts accepted writes so the controller can detect a completed frame.

Parameters:
- WIDTH_BITS, 8, column address width; WIDTH = 2**WIDTH_BITS.
- HEIGHT_BITS, 8, row address width; HEIGHT = 2**HEIGHT_BITS.
- H_BLANK, 16, blank columns per line after the active region; must be >= H_SYNC + 1.
- V_BLANK, 4, blank lines per frame after the active region; must be >= 2.
- H_SYNC, 8, hsync pulse length in clocks.

Ports:
- clock, input, 1, single system clock.
- reset, input, 1, asynchronous, active-high.
- iCol, input, WIDTH_BITS, write column (x).
- iRow, input, HEIGHT_BITS, write row (y).
- iR, input, 3, write red. iG, input, 3, write green. iB, input, 3, write blue.
- iWren, input, 1, write strobe; one pixel per asserted cycle.
- iClearCount, input, 1, synchronous clear of the write counter.
- oScanCol, output, WIDTH_BITS, column of the pixel currently on oScanR/G/B.
- oScanRow, output, HEIGHT_BITS, row of the pixel currently on oScanR/G/B.
- oScanR, output, 3. oScanG, output, 3. oScanB, output, 3. Scanned pixel.
- oScanValid, output, 1, scanned pixel lies in the active region.
- oHsync, output, 1, active-high line sync.
- oVsync, output, 1, active-high frame sync.
- oFrameStart, output, 1, one-cycle pulse aligned with pixel (0,0).
- oWriteCount, output, WIDTH_BITS+HEIGHT_BITS+1, accepted writes; saturating.
- oFrameFull, output, 1, high when oWriteCount == WIDTH*HEIGHT.

Behaviour:
- Memory: WIDTH*HEIGHT x 9 bits, address {iRow,iCol}, data {R,G,B}. Contents are not reset. Implementation must infer a simple dual-port RAM: one write port, one read port.
- Write: on a posedge with iWren=1, mem[{iRow,iCol}] <= {iR,iG,iB}. No backpressure; every strobe is accepted.
- Write counter:
  - Increments by 1 per iWren cycle and saturates at WIDTH*HEIGHT.
  - iClearCount sets it to 0. If iClearCount and iWren are high in the same cycle, the result is 0: clear wins and that write is not counted, but the write is still stored.
  - The counter counts strobes, not distinct addresses.
- Scan counters:
  - hcnt runs 0..WIDTH+H_BLANK-1, then wraps to 0.
  - vcnt increments when hcnt wraps and runs 0..HEIGHT+V_BLANK-1, then wraps to 0.
  - Both counters free-run from the first cycle after reset release.
- Active region: active = (hcnt < WIDTH) && (vcnt < HEIGHT). The read address {vcnt,hcnt} is issued in the same cycle.
- Pipeline, 1-cycle latency: every scan output is registered from the previous cycle's counters and RAM read.
  - oScanCol/oScanRow = the previous cycle's hcnt/vcnt, truncated to address width.
  - oScanValid = the previous cycle's active.
  - oScanR/G/B = RAM data when oScanValid is high, else 0.
- Sync (same 1-cycle delay):
  - oHsync = 1 for hcnt in [WIDTH, WIDTH+H_SYNC).
  - oVsync = 1 for the whole of line vcnt == HEIGHT.
  - oFrameStart = 1 when hcnt==0 && vcnt==0.
- Read/write collision: a write and a scan read to the same address in the same cycle returns the old data (read-first). The new data appears on the next frame.
- Reset, asserted at any time including mid-frame or mid-write:
  - hcnt, vcnt and write counter go to 0.
  - All outputs go to 0, including oScanValid, oHsync, oVsync, oFrameStart and oFrameFull.
  - A write in the cycle reset asserts may be lost.
  - After release, the first oFrameStart occurs exactly 1 cycle after the first active clock edge.
- Frame period = (WIDTH+H_BLANK)*(HEIGHT+V_BLANK) clocks; default 272*260 = 70720.

Test Plan:
- Reset -> all outputs 0. Release reset -> oFrameStart=1 with oScanValid=1, oScanCol=0, oScanRow=0 on the 1st cycle after the first clock edge. Next oFrameStart occurs 70720 cycles later.
- Write (col 5, row 2, R=7 G=0 B=3) once, then scan -> when oScanCol=5, oScanRow=2, oScanValid=1: oScanR=7, oScanG=0, oScanB=3. Neighbouring pixels keep prior contents.
- Timing per line: hold iWren=0 and observe one line -> oScanValid high for 256 cycles, then low for 16. oHsync high for exactly 8 cycles starting at the first blank cycle. oScanR/G/B=0 whenever oScanValid=0.
- Counter: stream 65536 writes with iWren=1 continuously -> oWriteCount=65536, oFrameFull=1. 10 more writes -> still 65536. Assert iClearCount with iWren=1 -> next cycle oWriteCount=0, oFrameFull=0.
- Collision: write 9'h1FF to the address the scan reads in the same cycle (old value 0) -> that frame outputs 0 there. The next frame outputs R=G=B=7.
- Mid-frame reset at hcnt=100, vcnt=50 -> outputs 0 immediately, asynchronously. After release, scan restarts at (0,0) with oFrameStart and oWriteCount=0.

Source files
------------

// File: rtl/result_frame_sink.sv
// Result pixel sink: frame buffer written by the threshold pipeline,
// raster-scanned out with sync pulses, plus a saturating write counter.
module result_frame_sink #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int H_BLANK     = 16,
    parameter int V_BLANK     = 4,
    parameter int H_SYNC      = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [WIDTH_BITS-1:0]            iCol,
    input  logic [HEIGHT_BITS-1:0]           iRow,
    input  logic [2:0]                       iR,
    input  logic [2:0]                       iG,
    input  logic [2:0]                       iB,
    input  logic                             iWren,
    input  logic                             iClearCount,
    output logic [WIDTH_BITS-1:0]            oScanCol,
    output logic [HEIGHT_BITS-1:0]           oScanRow,
    output logic [2:0]                       oScanR,
    output logic [2:0]                       oScanG,
    output logic [2:0]                       oScanB,
    output logic                             oScanValid,
    output logic                             oHsync,
    output logic                             oVsync,
    output logic                             oFrameStart,
    output logic [WIDTH_BITS+HEIGHT_BITS:0]  oWriteCount,
    output logic                             oFrameFull
);

    localparam int WIDTH   = 2**WIDTH_BITS;
    localparam int HEIGHT  = 2**HEIGHT_BITS;
    localparam int H_TOTAL = WIDTH + H_BLANK;
    localparam int V_TOTAL = HEIGHT + V_BLANK;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int AW      = WIDTH_BITS + HEIGHT_BITS;
    localparam int DEPTH   = 2**AW;

    localparam logic [HC_W-1:0] H_LAST  = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_LAST  = VC_W'(V_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT   = HC_W'(WIDTH);
    localparam logic [HC_W-1:0] H_SYEND = HC_W'(WIDTH + H_SYNC);
    localparam logic [VC_W-1:0] V_ACT   = VC_W'(HEIGHT);
    localparam logic [AW:0]     FULL    = {1'b1, {AW{1'b0}}};

    logic [8:0]      mem [DEPTH];
    logic [8:0]      rd_data;
    logic [HC_W-1:0] hcnt;
    logic [VC_W-1:0] vcnt;
    logic [AW-1:0]   raddr;
    logic [AW-1:0]   waddr;
    logic            active;
    logic            hsync_d;
    logic            vsync_d;
    logic            fstart_d;

    assign raddr    = {vcnt[HEIGHT_BITS-1:0], hcnt[WIDTH_BITS-1:0]};
    assign waddr    = {iRow, iCol};
    assign active   = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hsync_d  = (hcnt >= H_ACT) && (hcnt < H_SYEND);
    assign vsync_d  = (vcnt == V_ACT);
    assign fstart_d = (hcnt == '0) && (vcnt == '0);

    // Read-first simple dual-port RAM; contents deliberately not reset.
    always_ff @(posedge clock) begin
        if (iWren)
            mem[waddr] <= {iR, iG, iB};
        rd_data <= mem[raddr];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oScanCol    <= '0;
            oScanRow    <= '0;
            oScanValid  <= 1'b0;
            oHsync      <= 1'b0;
            oVsync      <= 1'b0;
            oFrameStart <= 1'b0;
        end else begin
            oScanCol    <= hcnt[WIDTH_BITS-1:0];
            oScanRow    <= vcnt[HEIGHT_BITS-1:0];
            oScanValid  <= active;
            oHsync      <= hsync_d;
            oVsync      <= vsync_d;
            oFrameStart <= fstart_d;
        end
    end

    // Blank cycles and reset both force the pixel to black.
    assign {oScanR, oScanG, oScanB} = oScanValid ? rd_data : 9'd0;

    // Clear beats a simultaneous strobe; saturates at one full frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            oWriteCount <= '0;
        else if (iClearCount)
            oWriteCount <= '0;
        else if (iWren && (oWriteCount != FULL))
            oWriteCount <= oWriteCount + 1'b1;
    end

    assign oFrameFull = (oWriteCount == FULL);

endmodule
